// File: rtl/io881_insn_pkg.sv
// io881_insn_pkg: opcode classes, opcode constants, decoder states and operand-count helper
package io881_insn_pkg;
  typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_TWO, CLS_JUMP} cls_e;
  typedef enum logic [1:0] {ST_IDLE, ST_OPND1, ST_OPND2, ST_HOLD} st_e;
  localparam logic [7:0] OP_NOOP     = 8'h00;
  localparam logic [7:0] OP_SUSPEND  = 8'h01;
  localparam logic [7:0] OP_PULL     = 8'h02;
  localparam logic [3:0] JUMP_PREFIX = 4'b1100;
  // Reserved 11xx opcodes fall into CLS_NONE so they always assemble as 1-byte ops
  function automatic cls_e op_class(input logic [7:0] b0);
    return b0[7:6] == 2'b00 ? CLS_NONE :
           b0[7:6] == 2'b01 ? CLS_ONE  :
           b0[7:6] == 2'b10 ? CLS_TWO  :
           b0[7:4] == JUMP_PREFIX ? CLS_JUMP : CLS_NONE;
  endfunction
  function automatic logic [1:0] n_opnd(input logic [7:0] b0);
    cls_e c;
    c = op_class(b0);
    return c == CLS_TWO ? 2'd2 : c == CLS_NONE ? 2'd0 : 2'd1;
  endfunction
  function automatic logic is_reserved(input logic [7:0] b0);
    return b0[7:6] == 2'b11 && b0[7:4] != JUMP_PREFIX;
  endfunction
endpackage

// File: rtl/insn_classify.sv
// insn_classify: combinational byte0 -> operand count and raw instruction flags
module insn_classify
  import io881_insn_pkg::*;
(
  input  logic [7:0] i_byte0,
  output logic [1:0] o_n_opnd,
  output logic       o_noop,
  output logic       o_suspend,
  output logic       o_pull,
  output logic       o_jump,
  output logic       o_reserved
);
  assign o_n_opnd   = n_opnd(i_byte0);
  assign o_noop     = i_byte0 == OP_NOOP;
  assign o_suspend  = i_byte0 == OP_SUSPEND;
  assign o_pull     = i_byte0 == OP_PULL;
  assign o_jump     = op_class(i_byte0) == CLS_JUMP;
  assign o_reserved = is_reserved(i_byte0);
endmodule

// File: rtl/insn_decode.sv
// insn_decode: assembles 1-3 byte instructions from ifetch and holds them until pulled.
// Define INSN_DECODE_ILLEGAL_TRAP_EN to add insn_illegal for reserved opcodes 0xD0-0xFF.
module insn_decode
  import io881_insn_pkg::*;
#(
  parameter int BYTE_W   = 8,
  parameter int INSN_W   = 3 * BYTE_W,
  parameter int TARGET_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BYTE_W-1:0]   opcode,
  input  logic                opcode_valid,
  input  logic                pull_decoded,
  output logic                need_operand,
  output logic                insn_valid,
  output logic [INSN_W-1:0]   decoded_insn,
  output logic [TARGET_W-1:0] jump_target,
  output logic                insn_noop,
  output logic                insn_suspend,
  output logic                insn_pull,
  output logic                insn_jump
`ifdef INSN_DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                insn_illegal
`endif
);
  st_e r_state, w_next;
  logic [BYTE_W-1:0] r_b0, r_b1, r_b2, w_cls_byte;
  logic r_noop, r_suspend, r_pull, r_jump;
  logic w_start, w_done, w_drop;
  logic [1:0] w_n_opnd;
  logic w_noop, w_suspend, w_pull, w_jump, w_reserved;
  // A new byte0 is taken in IDLE, or in HOLD when the held word is pulled the same cycle
  assign w_start    = opcode_valid && (r_state == ST_IDLE || (r_state == ST_HOLD && pull_decoded));
  assign w_drop     = r_state == ST_HOLD && pull_decoded && !opcode_valid;
  assign w_cls_byte = (r_state == ST_IDLE || r_state == ST_HOLD) ? opcode : r_b0;
  assign w_done     = (w_start && w_n_opnd == 2'd0) ||
                      (opcode_valid && r_state == ST_OPND1 && w_n_opnd == 2'd1) ||
                      (opcode_valid && r_state == ST_OPND2);
  insn_classify u_classify (
    .i_byte0    (w_cls_byte),
    .o_n_opnd   (w_n_opnd),
    .o_noop     (w_noop),
    .o_suspend  (w_suspend),
    .o_pull     (w_pull),
    .o_jump     (w_jump),
    .o_reserved (w_reserved)
  );
  always_comb begin
    w_next = w_start ? (w_n_opnd == 2'd0 ? ST_HOLD : ST_OPND1) :
             (opcode_valid && r_state == ST_OPND1) ? (w_n_opnd == 2'd2 ? ST_OPND2 : ST_HOLD) :
             (opcode_valid && r_state == ST_OPND2) ? ST_HOLD :
             w_drop ? ST_IDLE : r_state;
  end
`ifdef INSN_DECODE_ILLEGAL_TRAP_EN
  logic r_illegal;
  assign insn_illegal = r_illegal;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_b0      <= '0;
      r_b1      <= '0;
      r_b2      <= '0;
      r_noop    <= 1'b0;
      r_suspend <= 1'b0;
      r_pull    <= 1'b0;
      r_jump    <= 1'b0;
`ifdef INSN_DECODE_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_b0 <= opcode;
        r_b1 <= '0;
        r_b2 <= '0;
      end else if (opcode_valid && r_state == ST_OPND1) begin
        r_b1 <= opcode;
      end else if (opcode_valid && r_state == ST_OPND2) begin
        r_b2 <= opcode;
      end
      if (w_done) begin
        r_suspend <= w_suspend;
        r_pull    <= w_pull;
        r_jump    <= w_jump;
`ifdef INSN_DECODE_ILLEGAL_TRAP_EN
        r_noop    <= w_noop;
        r_illegal <= w_reserved;
`else
        r_noop    <= w_noop | w_reserved;
`endif
      end else if (w_start || w_drop) begin
        r_noop    <= 1'b0;
        r_suspend <= 1'b0;
        r_pull    <= 1'b0;
        r_jump    <= 1'b0;
`ifdef INSN_DECODE_ILLEGAL_TRAP_EN
        r_illegal <= 1'b0;
`endif
      end
    end
  end
  assign need_operand = r_state == ST_OPND1 || r_state == ST_OPND2;
  assign insn_valid   = r_state == ST_HOLD;
  assign decoded_insn = {r_b0, r_b1, r_b2};
  assign jump_target  = {r_b0[3:0], r_b1};
  assign insn_noop    = r_noop;
  assign insn_suspend = r_suspend;
  assign insn_pull    = r_pull;
  assign insn_jump    = r_jump;
endmodule

// File: doc/insn_decode.md
Name: insn_decode

Overview:
- Instruction decoder paired with the instruction fetch stage.
- Accepts opcode and operand bytes that ifetch reads from memory, and assembles 1-3 byte instructions into a 24-bit decoded word.
- Classifies each instruction (noop/suspend/pull/jump) and holds the result until ifetch pulls it with pull_decoded.
- need_operand tells ifetch to fetch another byte instead of starting a new instruction.

Parameters:
- BYTE_W, 8, width of each fetched byte (opcode/operand).
- INSN_W, 24, decoded word width; fixed at 3*BYTE_W.
- TARGET_W, 12, jump target width (matches ifetch jump_target).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  8  byte from ifetch (opcode or operand).
- opcode_valid  in  1  one-cycle strobe: opcode holds a new byte.
- pull_decoded  in  1  ifetch consumes the held decoded instruction.
- need_operand  out  1  more operand bytes are required for the current instruction.
- insn_valid  out  1  decoded_insn and flags are valid.
- decoded_insn  out  24  {byte0, byte1, byte2}; unused bytes are zero.
- jump_target  out  12  {byte0[3:0], byte1}; valid with insn_jump.
- insn_noop  out  1  decoded noop.
- insn_suspend  out  1  decoded suspend.
- insn_pull  out  1  decoded pull.
- insn_jump  out  1  decoded unconditional jump.

Behaviour:
- Encoding, by byte0[7:6]:
  - 00: no operands. 0x00 noop, 0x01 suspend, 0x02 pull; others are plain 1-byte ops.
  - 01: one operand.
  - 10: two operands.
  - 11: byte0[5:4]==00 is jump with one operand; 1101/1110/1111 are reserved (see Optional Feature).
- States: IDLE, OPND1, OPND2, HOLD. Reset (synchronous, clk edge) forces IDLE, clears byte registers, and drives every output to 0. This includes abandoning a partially assembled instruction.
- IDLE + opcode_valid: latch byte0 and clear byte1/byte2.
  - 1-byte class: go to HOLD.
  - Otherwise: go to OPND1 with need_operand=1 from the next cycle.
- OPND1 + opcode_valid: latch byte1.
  - 2-byte instruction: go to HOLD and drop need_operand.
  - 3-byte instruction: go to OPND2 with need_operand held.
- OPND2 + opcode_valid: latch byte2, go to HOLD, drop need_operand.
- Without opcode_valid, OPND states wait indefinitely.
- Latency: insn_valid rises on the clock edge that accepts the final byte, so it is visible the cycle after the final strobe.
- HOLD: insn_valid=1; outputs stable until pull_decoded.
  - pull_decoded alone: go to IDLE, insn_valid=0 next cycle.
  - pull_decoded + opcode_valid in the same cycle: the new byte is accepted as byte0 (back-to-back, no bubble).
  - opcode_valid without pull_decoded: ignored. This is a protocol violation; the bench asserts it never happens.
- pull_decoded outside HOLD: ignored.
- Flags are mutually exclusive. They are 0 whenever insn_valid=0, and are registered alongside decoded_insn.
- need_operand and insn_valid are never both 1.

Optional Feature:
- Macro: INSN_DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output insn_illegal (1 bit).
  - Reserved opcodes 0xD0-0xFF decode as 1-byte instructions with insn_illegal=1 and all other flags 0.
- Undefined:
  - No insn_illegal port.
  - Reserved opcodes decode as 1-byte noop with insn_noop=1 and decoded_insn={byte0,16'h0000}.

Decomposition:
- Shared package io881_insn_pkg:
  - opcode class enum (CLS_NONE/CLS_ONE/CLS_TWO/CLS_JUMP).
  - constants OP_NOOP=8'h00, OP_SUSPEND=8'h01, OP_PULL=8'h02, JUMP_PREFIX=4'b1100.
  - state enum.
  - function returning operand count from byte0.
- Sub-module insn_classify: purely combinational byte0 -> class/flags. Shared with the bench's reference model.
- The FSM and byte registers stay in insn_decode.

Test Plan:
- Reset, then opcode 8'h00 strobed -> next cycle insn_valid=1, insn_noop=1, decoded_insn=24'h000000, need_operand=0; pull_decoded -> insn_valid=0 next cycle.
- Opcode 8'h5A, then operand 8'hC3 -> need_operand=1 after first strobe; after second: decoded_insn=24'h5AC300, insn_valid=1, all flags 0.
- Opcode 8'hAA, operands 8'h11, 8'h22 with 3 idle cycles between -> need_operand held throughout; decoded_insn=24'hAA1122.
- Jump 8'hC3, operand 8'h45 -> insn_jump=1, jump_target=12'h345; then pull_decoded + opcode 8'h01 same cycle -> next insn suspend, no idle cycle.
- Reset asserted in OPND2 -> next cycle all outputs 0, state IDLE; subsequent 8'h02 decodes as pull.
- Opcode 8'hF0 -> with INSN_DECODE_ILLEGAL_TRAP_EN: insn_illegal=1; without: insn_noop=1, decoded_insn=24'hF00000.
